// File: rtl/uart_tx_scheduler.sv
// Round-robin arbiter sharing one UART transmitter among NREQ requesters.
// Captures the winner's byte/parity config, pulses tx_start, waits for tx_done or watchdog expiry.
//
//   state | meaning
//   IDLE  | arbitrate among pending requests, grant and capture winner
//   START | issue one-cycle tx_start, clear watchdog
//   WAIT  | wait for tx_done, abort on watchdog expiry
module uart_tx_scheduler #(
   parameter int unsigned DATAWIDTH = 8,
   parameter int unsigned NREQ      = 4,
   parameter int unsigned TIMEOUT   = 8192
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NREQ-1:0]           req,
   input  logic [NREQ*DATAWIDTH-1:0] req_data,
   input  logic [NREQ-1:0]           req_parEnable,
   input  logic [NREQ-1:0]           req_parityType,
   output logic [NREQ-1:0]           grant,
   output logic [NREQ-1:0]           done,
   output logic                      timeout_err,
   output logic                      busy,
   output logic [$clog2(NREQ)-1:0]   owner,
   output logic [DATAWIDTH-1:0]      tx_data,
   output logic                      tx_parEnable,
   output logic                      tx_parityType,
   output logic                      tx_start,
   input  logic                      tx_done
);

   localparam int unsigned OW  = $clog2(NREQ);
   localparam int unsigned WDW = $clog2(TIMEOUT + 1);
   localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);
   localparam logic [OW-1:0]  PTR_RST = OW'(NREQ - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      WAIT  = 2'd2
   } state_t;

   state_t                 state_q, state_d;
   logic [OW-1:0]          last_q, last_d;
   logic [OW-1:0]          owner_q, owner_d;
   logic [NREQ-1:0]        grant_q, grant_d;
   logic [NREQ-1:0]        done_q, done_d;
   logic                   tmo_q, tmo_d;
   logic                   busy_q, busy_d;
   logic [DATAWIDTH-1:0]   tx_data_q, tx_data_d;
   logic                   tx_pe_q, tx_pe_d;
   logic                   tx_pt_q, tx_pt_d;
   logic                   tx_start_q, tx_start_d;
   logic [WDW-1:0]         wd_q, wd_d;

   logic                   win_found;
   logic [OW-1:0]          win_idx;

   // Scan last+1, last+2, ... modulo NREQ; first asserted request wins.
   always_comb begin
      int idx;
      win_found = 1'b0;
      win_idx   = '0;
      idx       = 0;
      for (int off = 1; off <= int'(NREQ); off++) begin
         idx = (int'(last_q) + off) % int'(NREQ);
         if (!win_found && req[idx]) begin
            win_found = 1'b1;
            win_idx   = OW'(idx);
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      last_d     = last_q;
      owner_d    = owner_q;
      grant_d    = '0;
      done_d     = '0;
      tmo_d      = 1'b0;
      busy_d     = busy_q;
      tx_data_d  = tx_data_q;
      tx_pe_d    = tx_pe_q;
      tx_pt_d    = tx_pt_q;
      tx_start_d = 1'b0;
      wd_d       = wd_q;

      case (state_q)
         IDLE: begin
            if (win_found) begin
               grant_d   = NREQ'(1) << win_idx;
               owner_d   = win_idx;
               tx_data_d = req_data[int'(win_idx)*int'(DATAWIDTH) +: DATAWIDTH];
               tx_pe_d   = req_parEnable[win_idx];
               tx_pt_d   = req_parityType[win_idx];
               busy_d    = 1'b1;
               state_d   = START;
            end
         end
         START: begin
            tx_start_d = 1'b1;
            wd_d       = '0;
            state_d    = WAIT;
         end
         WAIT: begin
            wd_d = wd_q + WDW'(1);
            // tx_done takes priority over a watchdog expiry in the same cycle.
            if (tx_done) begin
               done_d  = NREQ'(1) << owner_q;
               last_d  = owner_q;
               busy_d  = 1'b0;
               state_d = IDLE;
            end else if (wd_q == WD_LAST) begin
               tmo_d   = 1'b1;
               last_d  = owner_q;
               busy_d  = 1'b0;
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= IDLE;
         last_q     <= PTR_RST;
         owner_q    <= '0;
         grant_q    <= '0;
         done_q     <= '0;
         tmo_q      <= 1'b0;
         busy_q     <= 1'b0;
         tx_data_q  <= '0;
         tx_pe_q    <= 1'b0;
         tx_pt_q    <= 1'b0;
         tx_start_q <= 1'b0;
         wd_q       <= '0;
      end else begin
         state_q    <= state_d;
         last_q     <= last_d;
         owner_q    <= owner_d;
         grant_q    <= grant_d;
         done_q     <= done_d;
         tmo_q      <= tmo_d;
         busy_q     <= busy_d;
         tx_data_q  <= tx_data_d;
         tx_pe_q    <= tx_pe_d;
         tx_pt_q    <= tx_pt_d;
         tx_start_q <= tx_start_d;
         wd_q       <= wd_d;
      end
   end

   assign grant         = grant_q;
   assign done          = done_q;
   assign timeout_err   = tmo_q;
   assign busy          = busy_q;
   assign owner         = owner_q;
   assign tx_data       = tx_data_q;
   assign tx_parEnable  = tx_pe_q;
   assign tx_parityType = tx_pt_q;
   assign tx_start      = tx_start_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Transaction-level bench: a round-robin reference model predicts each winner,
// and every frame's grant/start/done/abort timing is checked cycle by cycle.
module tb_uart_tx_scheduler;

   localparam int DW = 8;
   localparam int NR = 4;
   localparam int TO = 512;
   localparam int OW = 2;

   logic               clk = 1'b0;
   logic               rst = 1'b0;
   logic [NR-1:0]      req = '0;
   logic [NR*DW-1:0]   req_data = '0;
   logic [NR-1:0]      req_parEnable = '0;
   logic [NR-1:0]      req_parityType = '0;
   logic [NR-1:0]      grant;
   logic [NR-1:0]      done;
   logic               timeout_err;
   logic               busy;
   logic [OW-1:0]      owner;
   logic [DW-1:0]      tx_data;
   logic               tx_parEnable;
   logic               tx_parityType;
   logic               tx_start;
   logic               tx_done = 1'b0;

   int checks   = 0;
   int failures = 0;
   int last_m;

   uart_tx_scheduler #(.DATAWIDTH(DW), .NREQ(NR), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst), .req(req), .req_data(req_data),
      .req_parEnable(req_parEnable), .req_parityType(req_parityType),
      .grant(grant), .done(done), .timeout_err(timeout_err), .busy(busy),
      .owner(owner), .tx_data(tx_data), .tx_parEnable(tx_parEnable),
      .tx_parityType(tx_parityType), .tx_start(tx_start), .tx_done(tx_done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Reference: rotate priority so the index after the last owner comes first.
   function automatic int pick(input logic [NR-1:0] r, input int last);
      for (int off = 1; off <= NR; off++)
         if (r[(last + off) % NR]) return (last + off) % NR;
      return -1;
   endfunction

   task automatic check_reset_outputs(input string nm);
      chk({nm, "_grant"}, 32'(grant), 0);
      chk({nm, "_done"}, 32'(done), 0);
      chk({nm, "_tmo"}, 32'(timeout_err), 0);
      chk({nm, "_busy"}, 32'(busy), 0);
      chk({nm, "_owner"}, 32'(owner), 0);
      chk({nm, "_txdata"}, 32'(tx_data), 0);
      chk({nm, "_txpe"}, 32'(tx_parEnable), 0);
      chk({nm, "_txpt"}, 32'(tx_parityType), 0);
      chk({nm, "_txstart"}, 32'(tx_start), 0);
   endtask

   // Precondition: DUT idle, req nonzero. dly<0 means tx_done is never driven.
   task automatic run_frame(input int dly, input bit hold, input logic [NR-1:0] raise,
                            input string nm);
      int w;
      bit early;
      logic [DW-1:0] d_exp;
      logic pe_exp, pt_exp;
      w = pick(req, last_m);
      if (w < 0) begin
         checks++;
         failures++;
         $display("FAIL %s_nowinner req=%0h", nm, req);
         return;
      end
      d_exp  = req_data[w*DW +: DW];
      pe_exp = req_parEnable[w];
      pt_exp = req_parityType[w];
      tick;
      chk({nm, "_grant"}, 32'(grant), 32'(1 << w));
      chk({nm, "_owner"}, 32'(owner), 32'(w));
      chk({nm, "_txdata"}, 32'(tx_data), 32'(d_exp));
      chk({nm, "_txpe"}, 32'(tx_parEnable), 32'(pe_exp));
      chk({nm, "_txpt"}, 32'(tx_parityType), 32'(pt_exp));
      chk({nm, "_busy_grant"}, 32'(busy), 1);
      chk({nm, "_nostart"}, 32'(tx_start), 0);
      if (!hold) req[w] = 1'b0;
      tick;
      chk({nm, "_txstart"}, 32'(tx_start), 1);
      chk({nm, "_grant_off"}, 32'(grant), 0);
      req = req | raise;
      early = 0;
      if (dly >= 0) begin
         for (int i = 0; i < dly; i++) begin
            if (done != 0 || timeout_err || grant != 0 || busy !== 1'b1) early = 1;
            tick;
            if (tx_start) early = 1;
         end
         if (done != 0 || timeout_err || busy !== 1'b1) early = 1;
         tx_done = 1'b1;
         tick;
         tx_done = 1'b0;
         chk({nm, "_done"}, 32'(done), 32'(1 << w));
         chk({nm, "_tmo_off"}, 32'(timeout_err), 0);
         chk({nm, "_busy_end"}, 32'(busy), 0);
      end else begin
         for (int i = 0; i < TO; i++) begin
            if (done != 0 || timeout_err || grant != 0 || busy !== 1'b1) early = 1;
            tick;
            if (tx_start) early = 1;
         end
         chk({nm, "_tmo"}, 32'(timeout_err), 1);
         chk({nm, "_done_off"}, 32'(done), 0);
         chk({nm, "_busy_end"}, 32'(busy), 0);
      end
      chk({nm, "_no_early"}, 32'(early), 0);
      chk({nm, "_txdata_hold"}, 32'(tx_data), 32'(d_exp));
      last_m = w;
   endtask

   initial begin
      bit early;
      int dly;

      repeat (3) tick;
      check_reset_outputs("rst");
      rst = 1'b1;
      last_m = NR - 1;
      tick;

      req_data[7:0] = 8'hCD;
      req_parEnable[0] = 1'b1;
      req_parityType[0] = 1'b0;
      req = 4'b0001;
      run_frame(384, 0, '0, "single");

      req_data = {$urandom, $urandom};
      req_parEnable = 4'($urandom);
      req_parityType = 4'($urandom);
      req = 4'b1111;
      for (int i = 0; i < 5; i++) run_frame(int'($urandom_range(0, 6)), 1, '0, "fair");
      req = '0;

      req = 4'b0100;
      run_frame(20, 0, 4'b1010, "pend2");
      run_frame(5, 0, '0, "pend3");
      run_frame(5, 0, '0, "pend1");

      req = 4'b0010;
      run_frame(-1, 0, '0, "wdog");
      req = 4'b1000;
      run_frame(9, 0, '0, "after_wdog");

      req = 4'b0001;
      run_frame(TO - 1, 0, '0, "simul");

      req = 4'b0100;
      tick;
      req = '0;
      repeat (6) tick;
      rst = 1'b0;
      tick;
      rst = 1'b1;
      check_reset_outputs("midrst");
      early = 0;
      repeat (4) begin
         tick;
         if (done != 0 || timeout_err || grant != 0 || tx_start) early = 1;
      end
      chk("midrst_quiet", 32'(early), 0);
      last_m = NR - 1;
      req = 4'b1111;
      run_frame(3, 0, '0, "postrst");
      chk("postrst_owner0", 32'(owner), 0);
      req = '0;

      for (int n = 0; n < 24; n++) begin
         req_data = {$urandom, $urandom};
         req_parEnable = 4'($urandom);
         req_parityType = 4'($urandom);
         req = req | 4'($urandom_range(1, 15));
         dly = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 40));
         run_frame(dly, 1'($urandom_range(0, 1)), 4'($urandom), "rand");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
